// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared types and sizing helpers for the serializer slice
package shift_reg_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: modulo-WIDTH bit index with clear, enable and terminal-count flag
module bit_counter
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // index of the bit currently on the line; never passes WIDTH-1
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

    assign tc = cnt == TOP;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel word in, one bit per clock out, gapless back-to-back words
module piso_serializer
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ins,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             last,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic             tc;
    logic             xfer;
    logic             accept;

    assign busy       = state == SHIFT;
    assign sout_valid = busy;
    assign last       = busy & tc;
    assign sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign in_ready   = ~rst & (~busy | (last & sout_ready));
    assign xfer       = sout_valid & sout_ready;
    assign accept     = in_valid & in_ready;

    bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept | (xfer & last)),
        .en  (xfer & ~last),
        .tc  (tc)
    );

    // load on accept (including the final-bit edge), otherwise shift on each transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
        end else if (accept) begin
            state <= SHIFT;
            sreg  <= ins;
        end else if (xfer) begin
            sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            if (last) state <= IDLE;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: queue-based reference model, directed plan plus random traffic
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         sout_ready = 1'b1;
    logic [W-1:0] ins = '0;

    logic in_ready_m, sout_m, sv_m, last_m, busy_m;
    logic in_ready_l, sout_l, sv_l, last_l, busy_l;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int acc_cnt = 0;
    bit en_chk = 1'b0;

    bit qm[$];
    bit ql[$];
    bit cap_m[$];
    bit cap_l[$];
    bit cap_last[$];
    bit cap_rdy[$];
    int first_t = -1;
    int last_t = -1;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .in_valid   (in_valid),
        .in_ready   (in_ready_m),
        .sout       (sout_m),
        .sout_valid (sv_m),
        .sout_ready (sout_ready),
        .last       (last_m),
        .busy       (busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .in_valid   (in_valid),
        .in_ready   (in_ready_l),
        .sout       (sout_l),
        .sout_valid (sv_l),
        .sout_ready (sout_ready),
        .last       (last_l),
        .busy       (busy_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    function automatic bit exp_rdy();
        return !rst && (qm.size() == 0 || (qm.size() == 1 && sout_ready));
    endfunction

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // model: pending bits of the word in flight, oldest first
    always @(posedge clk) begin
        bit acc;
        cycle++;
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            acc = in_valid && exp_rdy();
            if (qm.size() > 0 && sout_ready) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                acc_cnt++;
                for (int i = 0; i < W; i++) begin
                    qm.push_back(ins[W-1-i]);
                    ql.push_back(ins[i]);
                end
            end
        end
    end

    // compare both instances against the model and log accepted bits
    always @(negedge clk) begin
        bit vm;
        if (en_chk) begin
            vm = qm.size() > 0;
            chk("valid_m", sv_m, vm);
            chk("valid_l", sv_l, vm);
            chk("busy_m", busy_m, vm);
            chk("busy_l", busy_l, vm);
            chk("last_m", last_m, qm.size() == 1);
            chk("last_l", last_l, qm.size() == 1);
            chk("in_ready_m", in_ready_m, exp_rdy());
            chk("in_ready_l", in_ready_l, exp_rdy());
            if (vm) begin
                chk("sout_m", sout_m, qm[0]);
                chk("sout_l", sout_l, ql[0]);
            end
            if (sv_m && sout_ready && !rst) begin
                cap_m.push_back(sout_m);
                cap_l.push_back(sout_l);
                cap_last.push_back(last_m);
                cap_rdy.push_back(in_ready_m);
                if (first_t < 0) first_t = cycle;
                last_t = cycle;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cap();
        cap_m.delete();
        cap_l.delete();
        cap_last.delete();
        cap_rdy.delete();
        first_t = -1;
        last_t = -1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (qm.size() > 0 && n < 50) begin
            cyc();
            n++;
        end
        chk("idle_timeout", qm.size(), 0);
    endtask

    initial begin
        int a0;
        int t0;
        int n;
        rst = 1'b1;
        cyc();
        en_chk = 1'b1;
        #2;
        chk("rst_sout", sout_m, 0);
        chk("rst_valid", sv_m, 0);
        chk("rst_last", last_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_in_ready", in_ready_m, 0);
        cyc();
        rst = 1'b0;

        clr_cap();
        ins = 4'b1010;
        in_valid = 1'b1;
        cyc();
        t0 = cycle;
        in_valid = 1'b0;
        wait_idle();
        cyc();
        chk("t1_msb", pack(cap_m), 32'b1010);
        chk("t1_lsb", pack(cap_l), 32'b0101);
        chk("t1_last", pack(cap_last), 32'b0001);
        chk("t1_len", cap_m.size(), 4);
        chk("t1_latency", first_t, t0);

        clr_cap();
        ins = 4'b1100;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_idle();
        chk("t2_lsb", pack(cap_l), 32'b0011);
        chk("t2_msb", pack(cap_m), 32'b1100);

        clr_cap();
        a0 = acc_cnt;
        ins = 4'b0111;
        in_valid = 1'b1;
        cyc();
        ins = 4'b0001;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 50) begin
            cyc();
            n++;
        end
        chk("t3_accepts", acc_cnt - a0, 2);
        in_valid = 1'b0;
        wait_idle();
        chk("t3_bits", pack(cap_m), 32'b01110001);
        chk("t3_len", cap_m.size(), 8);
        chk("t3_span", last_t - first_t + 1, 8);
        chk("t3_rdy", pack(cap_rdy), 32'b00010001);

        clr_cap();
        ins = 4'b1010;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        sout_ready = 1'b0;
        repeat (3) begin
            #2;
            chk("t4_hold_sout", sout_m, 0);
            chk("t4_hold_last", last_m, 0);
            chk("t4_stall_rdy", in_ready_m, 0);
            cyc();
        end
        sout_ready = 1'b1;
        cyc();
        cyc();
        sout_ready = 1'b0;
        in_valid = 1'b1;
        ins = 4'b0110;
        repeat (2) begin
            #2;
            chk("t4_last_stall_rdy", in_ready_m, 0);
            chk("t4_last_hold", last_m, 1);
            cyc();
        end
        in_valid = 1'b0;
        sout_ready = 1'b1;
        wait_idle();
        chk("t4_bits", pack(cap_m), 32'b1010);

        clr_cap();
        ins = 4'b1111;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        chk("t5_valid", sv_m, 0);
        chk("t5_sout", sout_m, 0);
        chk("t5_sout_l", sout_l, 0);
        chk("t5_busy", busy_m, 0);
        chk("t5_in_ready", in_ready_m, 1);
        chk("t5_emitted", cap_m.size(), 2);
        clr_cap();
        ins = 4'b0101;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_idle();
        chk("t5_bits", pack(cap_m), 32'b0101);

        rst = 1'b1;
        in_valid = 1'b1;
        ins = 4'b1001;
        #2;
        chk("t6_in_ready", in_ready_m, 0);
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("t6_busy", busy_m, 0);
        chk("t6_valid", sv_m, 0);

        repeat (3000) begin
            rst = $urandom_range(0, 99) == 0;
            in_valid = $urandom_range(0, 2) != 0;
            sout_ready = $urandom_range(0, 3) != 0;
            ins = W'($urandom);
            cyc();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        sout_ready = 1'b1;
        wait_idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
